// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates CHANNELS request ports onto one async SRAM bus.
// Define SRAM_ARB_RR_EN for round-robin; otherwise lowest index wins.
module sram_arbiter #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        reqValid,
  input  logic [CHANNELS-1:0]        reqWrite,
  input  logic [CHANNELS*ADDR_W-1:0] reqAddr,
  input  logic [CHANNELS*DATA_W-1:0] reqWdata,
  output logic [CHANNELS-1:0]        reqReady,
  output logic [CHANNELS-1:0]        rspValid,
  output logic [DATA_W-1:0]          rspData,
  inout  wire  [DATA_W-1:0]          memDataBus,
  output logic [ADDR_W-1:0]          memAddrBus,
  output logic                       memRead,
  output logic                       memWrite,
  output logic                       memEnable
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  state_t            stateNext;
  logic [CW-1:0]     waitCnt;
  logic [IW-1:0]     selIdx;
  logic [IW-1:0]     grantIdx;
  logic              selFound;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              selWrite;
  logic              wrReg;
  logic [DATA_W-1:0] wdataReg;
  logic              busDrive;

`ifdef SRAM_ARB_RR_EN
  logic [IW-1:0]         rrPtr;
  logic [2*CHANNELS-1:0] rotReq;

  assign rotReq = {reqValid, reqValid} >> rrPtr;
`endif

  // Pick the channel to grant from the pending requests
  always_comb begin
`ifdef SRAM_ARB_RR_EN
    int pos;
    pos = 0;
`endif
    selFound = 1'b0;
    selIdx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
`ifdef SRAM_ARB_RR_EN
      pos = int'(rrPtr) + k;
      if (pos >= CHANNELS) pos = pos - CHANNELS;
      if (!selFound && rotReq[k]) begin
        selFound = 1'b1;
        selIdx   = IW'(pos);
      end
`else
      if (!selFound && reqValid[k]) begin
        selFound = 1'b1;
        selIdx   = IW'(k);
      end
`endif
    end
  end

  // Route the selected channel's request fields
  always_comb begin
    selAddr  = '0;
    selWdata = '0;
    selWrite = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (selIdx == IW'(k)) begin
        selAddr  = reqAddr[k*ADDR_W +: ADDR_W];
        selWdata = reqWdata[k*DATA_W +: DATA_W];
        selWrite = reqWrite[k];
      end
    end
  end

  // State register; reset floats the bus and drops strobes at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= stateNext;

  // Next state, SRAM strobes and handshake pulses
  always_comb begin
    stateNext = state;
    memEnable = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b1;
    busDrive  = 1'b0;
    unique case (state)
      IDLE: begin
        if (selFound) stateNext = SETUP;
      end
      SETUP: begin
        stateNext = ACCESS;
        memEnable = 1'b0;
        memRead   = wrReg;
        busDrive  = wrReg;
      end
      ACCESS: begin
        if (waitCnt == '0) stateNext = DONE;
        memEnable = 1'b0;
        memRead   = wrReg;
        memWrite  = !wrReg;
        busDrive  = wrReg;
      end
      DONE: begin
        stateNext = IDLE;
        busDrive  = wrReg;
      end
      default: stateNext = IDLE;
    endcase
    for (int k = 0; k < CHANNELS; k++) begin
      reqReady[k] = rst && (state == IDLE) && selFound
                    && (selIdx == IW'(k));
      rspValid[k] = (state == DONE) && (grantIdx == IW'(k));
    end
  end

  assign memDataBus = busDrive ? wdataReg : {DATA_W{1'bz}};

  // Latch the granted request, count wait states, capture read data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      memAddrBus <= '0;
      wdataReg   <= '0;
      wrReg      <= 1'b0;
      grantIdx   <= '0;
      waitCnt    <= '0;
      rspData    <= '0;
    end else begin
      if (state == IDLE && selFound) begin
        memAddrBus <= selAddr;
        wdataReg   <= selWdata;
        wrReg      <= selWrite;
        grantIdx   <= selIdx;
      end
      if (state == SETUP)
        waitCnt <= CW'(WAIT_CYCLES - 1);
      else if (state == ACCESS && waitCnt != '0)
        waitCnt <= waitCnt - CW'(1);
      if (state == ACCESS && waitCnt == '0 && !wrReg)
        rspData <= memDataBus;
    end

`ifdef SRAM_ARB_RR_EN
  // Move the round-robin pointer just past each granted channel
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      rrPtr <= '0;
    else if (state == IDLE && selFound)
      rrPtr <= (int'(selIdx) == CHANNELS - 1) ? '0 : selIdx + IW'(1);
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: 3-port/1-wait instance against a cycle model,
// plus a 1-port/3-wait instance for wait-state timing.
module tb_sram_arbiter;
  localparam int N  = 3;
  localparam int W  = 1;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    reqValid, reqWrite, reqReady, rspValid;
  logic [N*AW-1:0] reqAddr;
  logic [N*DW-1:0] reqWdata;
  logic [DW-1:0]   rspData;
  wire  [DW-1:0]   memBus;
  logic [AW-1:0]   memAddr;
  logic            memRd, memWr, memEn;

  sram_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW),
                 .WAIT_CYCLES(W)) dutA (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWdata(reqWdata), .reqReady(reqReady),
    .rspValid(rspValid), .rspData(rspData), .memDataBus(memBus),
    .memAddrBus(memAddr), .memRead(memRd), .memWrite(memWr),
    .memEnable(memEn));

  logic          bValid, bWrite, bReady, bRsp;
  logic [AW-1:0] bAddr, bAddrBus;
  logic [DW-1:0] bWdata, bRdata;
  wire  [DW-1:0] bBus;
  logic          bRd, bWr, bEn;

  sram_arbiter #(.CHANNELS(1), .ADDR_W(AW), .DATA_W(DW),
                 .WAIT_CYCLES(3)) dutB (
    .clk(clk), .rst(rst), .reqValid(bValid), .reqWrite(bWrite),
    .reqAddr(bAddr), .reqWdata(bWdata), .reqReady(bReady),
    .rspValid(bRsp), .rspData(bRdata), .memDataBus(bBus),
    .memAddrBus(bAddrBus), .memRead(bRd), .memWrite(bWr),
    .memEnable(bEn));

  // SRAM environment for instance A, plus a parking driver that
  // makes any stray DUT drive on an idle bus visible.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic          parkEn;
  logic [DW-1:0] parkVal;
  assign memBus = (!memEn && !memRd) ? sram[memAddr] : 'z;
  assign memBus = parkEn ? parkVal : 'z;
  always @(posedge clk) if (!memEn && !memWr) sram[memAddr] <= memBus;
  assign bBus = (!bEn && !bRd) ? 16'hBEEF : 16'hzzzz;

  int total = 0;
  int bad   = 0;

  // reference model state
  int            cyc, busyStart, curCh, ptr, doneCnt;
  logic          curWr;
  logic [AW-1:0] curAddr, lastAddr;
  logic [DW-1:0] curData, curExp, lastRsp;
  logic [DW-1:0] refMem [int];
  int            grantLog[$];
  logic [N-1:0]  accLast;
  logic          bReadyS, bRspS, bOeS;
  logic [DW-1:0] bDataS;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
`ifdef SRAM_ARB_RR_EN
      if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
      if (v[k]) return k;
`endif
    end
    return -1;
  endfunction

  task automatic setReq(input int ch, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[ch]          = 1'b1;
    reqWrite[ch]          = w;
    reqAddr[ch*AW +: AW]  = a;
    reqWdata[ch*DW +: DW] = d;
  endtask

  // check one cycle of instance A against the model, then advance
  task automatic tick();
    int off, g;
    logic [N-1:0] expGrant, expRsp;
    logic expEn, expRd, expWr;
    bit act;
    #1;
    if (busyStart >= 0 && cyc > busyStart + 2 + W) busyStart = -1;
    off = (busyStart >= 0) ? cyc - busyStart : -1;
    expGrant = '0;
    g = -1;
    if (busyStart < 0) begin
      g = arb(reqValid);
      if (g >= 0) expGrant[g] = 1'b1;
    end
    chk("reqReady", reqReady, expGrant);
    act   = off >= 1 && off <= 1 + W;
    expEn = !act;
    expRd = !(act && !curWr);
    expWr = !(off >= 2 && off <= 1 + W && curWr);
    chk("strobes", {memEn, memRd, memWr}, {expEn, expRd, expWr});
    chk("memAddrBus", memAddr, lastAddr);
    expRsp = '0;
    if (off == 2 + W) begin
      expRsp[curCh] = 1'b1;
      if (!curWr) lastRsp = curExp;
      doneCnt++;
    end
    chk("rspValid", rspValid, expRsp);
    chk("rspData", rspData, lastRsp);
    if (curWr && off >= 1 && off <= 2 + W) chk("busWrite", memBus, curData);
    else if (!curWr && act) chk("busRead", memBus, curExp);
    else chk("busFloat", memBus, parkVal);
    bReadyS = bReady;
    bRspS   = bRsp;
    bOeS    = !bRd;
    bDataS  = bRdata;
    accLast = expGrant;
    if (g >= 0) begin
      busyStart = cyc;
      curCh     = g;
      curWr     = reqWrite[g];
      curAddr   = reqAddr[g*AW +: AW];
      curData   = reqWdata[g*DW +: DW];
      curExp    = refMem.exists(int'(curAddr)) ? refMem[int'(curAddr)] : '0;
      if (curWr) refMem[int'(curAddr)] = curData;
      lastAddr  = curAddr;
      ptr       = (g + 1) % N;
      grantLog.push_back(g);
    end
    @(negedge clk);
    cyc++;
    reqValid = reqValid & ~accLast;
    parkVal  = cyc[0] ? 16'hFFFF : 16'h0000;
    off = (busyStart >= 0) ? cyc - busyStart : -1;
    parkEn = !(off >= 1 && ((curWr && off <= 2 + W) ||
                            (!curWr && off <= 1 + W)));
  endtask

  initial begin
    int oe, rspAt, start;
    int exp4 [4];
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    rst = 1'b0;
    reqValid = '0; reqWrite = '0; reqAddr = '0; reqWdata = '0;
    bValid = 1'b0; bWrite = 1'b0; bAddr = '0; bWdata = '0;
    parkEn = 1'b1; parkVal = '0;
    cyc = 0; busyStart = -1; curCh = 0; curWr = 1'b0; ptr = 0;
    doneCnt = 0; lastAddr = '0; lastRsp = '0; curAddr = '0;
    curData = '0; curExp = '0; accLast = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_reqReady", reqReady, 0);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_rspData", rspData, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_strobes", {memEn, memRd, memWr}, 3'b111);
    chk("rst_bus", memBus, 16'h0000);
    chk("rst_b_strobes", {bEn, bRd, bWr}, 3'b111);
    chk("rst_b_rsp", {bReady, bRsp}, 2'b00);
    reqValid = 3'b111;
    #1;
    chk("rst_no_ready", reqReady, 0);
    reqValid = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // write then read back on ch0
    setReq(0, 1'b1, 18'h00ABC, 16'h1234);
    repeat (5) tick();
    setReq(0, 1'b0, 18'h00ABC, 16'h0000);
    repeat (6) tick();
    chk("rd_abc", rspData, 16'h1234);

    // ch1 withdraws while ch0 is in flight
    setReq(0, 1'b1, 18'h00100, 16'h5555);
    tick();
    setReq(1, 1'b0, 18'h00200, 16'h0000);
    repeat (2) tick();
    reqValid[1] = 1'b0;
    repeat (4) tick();

    // reset lands in ACCESS of a write
    setReq(0, 1'b1, 18'h3FFFF, 16'hA5A5);
    repeat (2) tick();
    #2;
    rst = 1'b0;
    parkEn = 1'b1;
    parkVal = 16'h0000;
    #1;
    chk("arst_strobes", {memEn, memRd, memWr}, 3'b111);
    chk("arst_bus", memBus, 16'h0000);
    chk("arst_rspValid", rspValid, 0);
    chk("arst_rspData", rspData, 0);
    chk("arst_memAddr", memAddr, 0);
    refMem.delete(int'(18'h3FFFF));
    busyStart = -1; ptr = 0; lastAddr = '0; lastRsp = '0;
    reqValid = '0;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    rst = 1'b1;
    tick();
    setReq(2, 1'b1, 18'h00010, 16'h7777);
    repeat (5) tick();
    setReq(2, 1'b0, 18'h00010, 16'h0000);
    repeat (6) tick();
    chk("post_rst_rd", rspData, 16'h7777);

    // all three ports contend and re-request at once
    grantLog.delete();
    for (int c = 0; c < N; c++) setReq(c, 1'b0, AW'(c), '0);
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int c = 0; c < N; c++)
        if (!reqValid[c]) setReq(c, 1'b0, AW'(c), '0);
    end
    reqValid = '0;
    repeat (4) tick();
`ifdef SRAM_ARB_RR_EN
    exp4 = '{0, 1, 2, 0};
`else
    exp4 = '{0, 0, 0, 0};
`endif
    chk("cont_count", grantLog.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grantLog.size()) chk("cont_order", grantLog[k], exp4[k]);

    // three wait states on instance B
    bValid = 1'b1; bWrite = 1'b0; bAddr = 18'h00007;
    tick();
    chk("b_accept", bReadyS, 1'b1);
    bValid = 1'b0;
    oe = 0;
    rspAt = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("b_ready_low", bReadyS, 1'b0);
      if (bOeS) oe++;
      if (bRspS) begin
        if (rspAt < 0) rspAt = k;
        chk("b_data", bDataS, 16'hBEEF);
      end
    end
    chk("b_oe_cycles", oe, 4);
    chk("b_rsp_at", rspAt, 5);

    // random read/write mix with random withdrawals
    start = doneCnt;
    for (int i = 0; i < 12000 && doneCnt - start < 1000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!reqValid[c]) begin
          if ($urandom_range(2) == 0)
            setReq(c, 1'($urandom_range(1)), AW'($urandom_range(63)),
                   DW'($urandom));
        end else if ($urandom_range(7) == 0) begin
          reqValid[c] = 1'b0;
        end
      end
      tick();
    end
    chk("rand_count", (doneCnt - start) >= 1000, 1'b1);
    reqValid = '0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised successor to the two-port external-SRAM path on the motherboard. Arbitrates `CHANNELS` independent request ports (CPU fetch, CPU data, graphics, DMA, …) onto the single asynchronous SRAM bus (`memDataBus`/`memAddrBus`/`memRead`/`memWrite`/`memEnable`). Each access runs a fixed-length strobe sequence with configurable wait states. Every port gets a valid/ready request handshake and a one-cycle completion pulse.

## Interface
- `CHANNELS`, 2: number of request ports, ≥1
- `ADDR_W`, 18: SRAM word-address width
- `DATA_W`, 16: SRAM data width
- `WAIT_CYCLES`, 1: cycles in which the strobe is held active, ≥1; 0 is illegal
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `reqValid`  in  CHANNELS  per-channel request pending
- `reqWrite`  in  CHANNELS  1 = write, 0 = read
- `reqAddr`  in  CHANNELS*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W]
- `reqWdata`  in  CHANNELS*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- `reqReady`  out  CHANNELS  one-hot, one-cycle accept pulse
- `rspValid`  out  CHANNELS  one-hot, one-cycle completion pulse (reads and writes)
- `rspData`  out  DATA_W  read data; valid while any `rspValid` bit is high
- `memDataBus`  inout  DATA_W  SRAM data; high-Z unless a write is in progress
- `memAddrBus`  out  ADDR_W  SRAM address
- `memRead`  out  1  OE, active-low
- `memWrite`  out  1  WE, active-low
- `memEnable`  out  1  CE, active-low

## Operation
- FSM states: IDLE → SETUP → ACCESS (WAIT_CYCLES cycles, down-counter) → DONE → IDLE.
- IDLE:
  - If any `reqValid` is set, select one channel g and pulse `reqReady[g]`.
  - Latch `reqAddr`/`reqWdata`/`reqWrite` of g into internal registers, then go to SETUP.
  - The channel may drop or change its inputs after `reqReady`.
- SETUP:
  - `memAddrBus` = latched address; `memEnable`=0.
  - Read: `memRead`=0.
  - Write: drive latched data on `memDataBus`; `memRead`=1.
- ACCESS:
  - Strobes as in SETUP.
  - Write: `memWrite`=0.
  - Read: `memDataBus` is registered into `rspData` on the final ACCESS edge.
- DONE:
  - `memEnable`=`memRead`=`memWrite`=1.
  - Write: data is still driven in this cycle (hold time).
  - Pulse `rspValid[g]`.
  - `rspData` holds the read value. On a write it keeps its previous value.
- Requesters must hold `reqValid` high with stable fields until `reqReady`. Lowering `reqValid` before accept withdraws the request without any side effect.
- `memAddrBus` holds the last address when idle.
- `memDataBus` is high-Z in IDLE and for the whole of every read.
- Only one access is ever in flight. Requests from other channels wait in IDLE.

## Timing
- Accept at edge T (IDLE).
  - SETUP is T+1.
  - ACCESS is T+2 … T+1+WAIT_CYCLES.
  - DONE / `rspValid` is T+2+WAIT_CYCLES.
  - Next accept is no earlier than T+3+WAIT_CYCLES.
- Throughput: one access per 3+WAIT_CYCLES cycles.
- WE low-pulse width = WAIT_CYCLES cycles. Data setup ≥1 cycle before WE falls; data held 1 cycle after WE rises.
- Reset values:
  - `reqReady`=0, `rspValid`=0, `rspData`=0.
  - `memAddrBus`=0; `memRead`=`memWrite`=`memEnable`=1.
  - `memDataBus` high-Z; FSM in IDLE.
  - Round-robin pointer = 0.
- Reset asserted mid-access: strobes deassert and the bus floats immediately (asynchronously). The in-flight access is dropped with no `rspValid`. The SRAM contents for an interrupted write are undefined.
- `CHANNELS`=1: arbitration degenerates; timing is unchanged.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Round-robin arbitration. The search starts at the pointer; after each grant, pointer = (g+1) mod CHANNELS.
  - No channel waits more than CHANNELS−1 grants.
- Not defined:
  - Fixed priority; the lowest index wins.
  - The pointer register is not built.

## Test plan
- Single write then read, WAIT_CYCLES=1, ch0:
  - Write 0x1234 to 0x00ABC: `reqReady[0]` at T; WE low only at T+2; data driven T+1..T+3; `rspValid[0]` at T+3.
  - Subsequent read of 0x00ABC: `rspData`=0x1234 on `rspValid[0]`.
- Contention, CHANNELS=3, all valid at once:
  - With `SRAM_ARB_RR_EN`: grant order 0,1,2,0.
  - Without the macro and ch0 held valid: ch0 is granted every 4 cycles, ch1/ch2 never.
- Withdraw: ch1 raises `reqValid` while ch0 is in flight, then drops it before IDLE. No `reqReady[1]`, no bus activity for ch1.
- WAIT_CYCLES=3 read: OE low for 4 cycles; `rspValid` exactly 5 cycles after accept; model returning 0xBEEF yields `rspData`=0xBEEF.
- Reset during the ACCESS state of a write:
  - `memWrite`/`memEnable` go to 1 and `memDataBus` floats within the same cycle; no `rspValid`.
  - After release, a new request is accepted normally.
- Bus-contention check: `memDataBus` is never driven while `memRead`=0, across 1000 random read/write mixes.
